// File: rtl/clock_phase_gen.sv
// Multi-phase clock-enable generator: N_CH programmable phase/width channels within a shared period.
// Configuration is shadowed and swapped in at period boundaries; stop always completes the current period.
module clock_phase_gen #(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 3,
  parameter int DEF_PERIOD = 8,
  parameter int DEF_WIDTH  = 4,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_phase,
  input  logic [CNT_W-1:0] cfg_width,
  input  logic             cfg_period_we,
  input  logic [CNT_W-1:0] cfg_period,
  output logic             cfg_err,
  output logic [N_CH-1:0]  phase_out,
  output logic [N_CH-1:0]  phase_rise,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             period_start,
  output logic             running
);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [CNT_W:0]   span_t;

  localparam cnt_t DEF_P    = cnt_t'(DEF_PERIOD);
  localparam cnt_t DEF_W    = cnt_t'(DEF_WIDTH);
  localparam int   DEF_STEP = DEF_PERIOD / N_CH;

  // A stored period of 0 stands for the full 2**CNT_W count.
  function automatic span_t span(input cnt_t p);
    return (p == '0) ? span_t'(1 << CNT_W) : span_t'(p);
  endfunction

  function automatic logic chan_level(input cnt_t c, input cnt_t ph, input cnt_t w, input span_t p);
    span_t off;
    off = (c >= ph) ? span_t'(c - ph) : span_t'(c) + p - span_t'(ph);
    return off < span_t'(w);
  endfunction

  state_t state, state_n;
  cnt_t   cnt, cnt_n;
  cnt_t   act_p, act_p_n, pend_p, pend_p_n;
  cnt_t   act_ph  [N_CH];
  cnt_t   act_w   [N_CH];
  cnt_t   pend_ph [N_CH];
  cnt_t   pend_w  [N_CH];
  cnt_t   act_ph_n  [N_CH];
  cnt_t   act_w_n   [N_CH];
  cnt_t   pend_ph_n [N_CH];
  cnt_t   pend_w_n  [N_CH];

  logic            ch_valid, period_ok, err_n;
  logic            wrap, load, ps_n;
  logic [N_CH-1:0] out_n, rise_n;

  if ((1 << CH_W) > N_CH) begin : g_ch_chk
    assign ch_valid = (int'(cfg_ch) < N_CH);
  end else begin : g_ch_all
    assign ch_valid = 1'b1;
  end

  // Write validation: the period is judged against current pending phases, then a
  // same-cycle phase write is judged against whichever pending period results.
  always_comb begin
    // NOTE: every variable gets a default first so no path through the block infers a latch.
    pend_p_n  = pend_p;
    pend_ph_n = pend_ph;
    pend_w_n  = pend_w;
    err_n     = 1'b0;
    period_ok = 1'b1;
    if (cfg_period_we) begin
      for (int i = 0; i < N_CH; i++)
        if (span(cfg_period) < span_t'(pend_ph[i])) period_ok = 1'b0;
      if (period_ok) pend_p_n = cfg_period;
      else           err_n    = 1'b1;
    end
    if (cfg_we) begin
      if (!ch_valid || span_t'(cfg_phase) >= span(pend_p_n)) begin
        err_n = 1'b1;
      end else begin
        pend_ph_n[cfg_ch] = cfg_phase;
        pend_w_n[cfg_ch]  = cfg_width;
      end
    end
  end

  assign wrap = (state != IDLE) && (cnt == act_p - cnt_t'(1));
  assign load = (state == IDLE) || wrap;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:     if (enable) state_n = RUN;
      RUN:      if (!enable) state_n = wrap ? IDLE : STOPPING;
      STOPPING: if (enable) state_n = RUN;
                else if (wrap) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
    cnt_n = (state == IDLE || state_n == IDLE || wrap) ? '0 : cnt + cnt_t'(1);
    act_p_n  = load ? pend_p_n  : act_p;
    act_ph_n = load ? pend_ph_n : act_ph;
    act_w_n  = load ? pend_w_n  : act_w;
  end

  // Outputs are computed from next-cycle state so that they all register together.
  always_comb begin
    out_n = '0;
    for (int i = 0; i < N_CH; i++)
      out_n[i] = (state_n != IDLE) && chan_level(cnt_n, act_ph_n[i], act_w_n[i], span(act_p_n));
    rise_n = out_n & ~phase_out;
    ps_n   = (state_n != IDLE) && (cnt_n == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the config arrays are a handful of flops, not a RAM, so resetting them is intended.
      state  <= IDLE;
      cnt    <= '0;
      act_p  <= DEF_P;
      pend_p <= DEF_P;
      for (int i = 0; i < N_CH; i++) begin
        act_ph[i]  <= cnt_t'(i * DEF_STEP);
        pend_ph[i] <= cnt_t'(i * DEF_STEP);
        act_w[i]   <= DEF_W;
        pend_w[i]  <= DEF_W;
      end
      cfg_err      <= 1'b0;
      phase_out    <= '0;
      phase_rise   <= '0;
      period_start <= 1'b0;
      running      <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every register sees pre-edge values of the others.
      state        <= state_n;
      cnt          <= cnt_n;
      act_p        <= act_p_n;
      pend_p       <= pend_p_n;
      act_ph       <= act_ph_n;
      act_w        <= act_w_n;
      pend_ph      <= pend_ph_n;
      pend_w       <= pend_w_n;
      cfg_err      <= err_n;
      phase_out    <= out_n;
      phase_rise   <= rise_n;
      period_start <= ps_n;
      running      <= (state_n != IDLE);
    end
  end

  assign cycle_cnt = cnt;

endmodule

// File: tb/tb_clock_phase_gen.sv
// Bench for clock_phase_gen: a period/offset arithmetic model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_clock_phase_gen;
  localparam int N_CH       = 4;
  localparam int CNT_W      = 3;
  localparam int CH_W       = 2;
  localparam int DEF_PERIOD = 8;
  localparam int DEF_WIDTH  = 4;

  logic             clock = 1'b0;
  logic             reset, enable, cfg_we, cfg_period_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_phase, cfg_width, cfg_period;
  logic             cfg_err, period_start, running;
  logic [N_CH-1:0]  phase_out, phase_rise;
  logic [CNT_W-1:0] cycle_cnt;

  int total = 0;
  int bad   = 0;

  clock_phase_gen #(.N_CH(N_CH), .CNT_W(CNT_W), .DEF_PERIOD(DEF_PERIOD), .DEF_WIDTH(DEF_WIDTH)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_phase(cfg_phase), .cfg_width(cfg_width),
    .cfg_period_we(cfg_period_we), .cfg_period(cfg_period),
    .cfg_err(cfg_err), .phase_out(phase_out), .phase_rise(phase_rise),
    .cycle_cnt(cycle_cnt), .period_start(period_start), .running(running)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: active/pending config as integers, position in period, running flag.
  // While running, only the last cycle of a period consults enable.
  int m_P, p_P, m_pos;
  int m_ph [N_CH];
  int m_w  [N_CH];
  int p_ph [N_CH];
  int p_w  [N_CH];
  bit m_run;
  logic [N_CH-1:0] e_out, e_rise;
  logic e_ps, e_err;

  always @(posedge clock) begin : model
    bit err, wrap, run_n, ok, lvl;
    int np;
    if (reset) begin
      m_run = 1'b0; m_pos = 0; m_P = DEF_PERIOD; p_P = DEF_PERIOD;
      for (int i = 0; i < N_CH; i++) begin
        m_ph[i] = i * (DEF_PERIOD / N_CH); p_ph[i] = m_ph[i];
        m_w[i]  = DEF_WIDTH;               p_w[i]  = DEF_WIDTH;
      end
      e_out = '0; e_rise = '0; e_ps = 1'b0; e_err = 1'b0;
    end else begin
      err = 1'b0;
      if (cfg_period_we) begin
        np = (cfg_period == 0) ? (1 << CNT_W) : int'(cfg_period);
        ok = 1'b1;
        for (int i = 0; i < N_CH; i++) if (np < p_ph[i]) ok = 1'b0;
        if (ok) p_P = np; else err = 1'b1;
      end
      if (cfg_we) begin
        if (int'(cfg_phase) >= p_P) err = 1'b1;
        else begin p_ph[cfg_ch] = int'(cfg_phase); p_w[cfg_ch] = int'(cfg_width); end
      end
      wrap  = m_run && (m_pos == m_P - 1);
      run_n = (m_run && !wrap) ? 1'b1 : enable;
      if (!m_run || wrap) begin
        m_P = p_P;
        for (int i = 0; i < N_CH; i++) begin m_ph[i] = p_ph[i]; m_w[i] = p_w[i]; end
      end
      m_pos = (m_run && run_n && !wrap) ? m_pos + 1 : 0;
      m_run = run_n;
      for (int i = 0; i < N_CH; i++) begin
        lvl = m_run && (((m_pos - m_ph[i] + m_P) % m_P) < m_w[i]);
        e_rise[i] = lvl & ~e_out[i];
        e_out[i]  = lvl;
      end
      e_ps  = m_run && (m_pos == 0);
      e_err = err;
    end
  end

  always @(negedge clock) begin
    check("phase_out",    32'(phase_out),    32'(e_out));
    check("phase_rise",   32'(phase_rise),   32'(e_rise));
    check("period_start", 32'(period_start), 32'(e_ps));
    check("running",      32'(running),      32'(m_run));
    check("cycle_cnt",    32'(cycle_cnt),    32'(m_pos));
    check("cfg_err",      32'(cfg_err),      32'(e_err));
  end

  task automatic wait_cnt(input int target);
    int n;
    n = 0;
    do begin @(negedge clock); n++; end while (int'(cycle_cnt) != target && n < 40);
    if (int'(cycle_cnt) != target) check("wait_cnt_timeout", 32'(cycle_cnt), 32'(target));
  endtask

  task automatic write_ch(input int ch, input int ph, input int w);
    cfg_we = 1'b1; cfg_ch = CH_W'(ch); cfg_phase = CNT_W'(ph); cfg_width = CNT_W'(w);
    @(negedge clock);
    cfg_we = 1'b0;
  endtask

  task automatic write_period(input int p);
    cfg_period_we = 1'b1; cfg_period = CNT_W'(p);
    @(negedge clock);
    cfg_period_we = 1'b0;
  endtask

  task automatic write_both(input int p, input int ch, input int ph, input int w);
    cfg_period_we = 1'b1; cfg_period = CNT_W'(p);
    cfg_we = 1'b1; cfg_ch = CH_W'(ch); cfg_phase = CNT_W'(ph); cfg_width = CNT_W'(w);
    @(negedge clock);
    cfg_period_we = 1'b0; cfg_we = 1'b0;
  endtask

  // Default config after enable: ch0 0-3, ch1 2-5, ch2 4-7, ch3 6-1.
  task automatic check_default_pattern();
    @(negedge clock);
    check("lit_c0_cnt",  32'(cycle_cnt),    32'd0);
    check("lit_c0_out",  32'(phase_out),    32'h9);
    check("lit_c0_rise", 32'(phase_rise),   32'h9);
    check("lit_c0_ps",   32'(period_start), 32'd1);
    check("lit_c0_run",  32'(running),      32'd1);
    repeat (2) @(negedge clock);
    check("lit_c2_out",  32'(phase_out),    32'h3);
    check("lit_c2_rise", 32'(phase_rise),   32'h2);
    repeat (2) @(negedge clock);
    check("lit_c4_out",  32'(phase_out),    32'h6);
    check("lit_c4_rise", 32'(phase_rise),   32'h4);
    repeat (2) @(negedge clock);
    check("lit_c6_out",  32'(phase_out),    32'hC);
    check("lit_c6_rise", 32'(phase_rise),   32'h8);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; cfg_we = 1'b0; cfg_period_we = 1'b0;
    cfg_ch = '0; cfg_phase = '0; cfg_width = '0; cfg_period = '0;
    repeat (3) @(negedge clock);
    check("rst_out", 32'(phase_out), 32'd0);
    check("rst_run", 32'(running),   32'd0);
    check("rst_cnt", 32'(cycle_cnt), 32'd0);
    check("rst_ps",  32'(period_start), 32'd0);
    reset = 1'b0; enable = 1'b1;
    check_default_pattern();

    // Shadowed write mid-period: ch1 becomes a single pulse at cnt 5 next period.
    wait_cnt(3);
    write_ch(1, 5, 1);
    check("wr_err",     32'(cfg_err),   32'd0);
    check("wr_c4_same", 32'(phase_out), 32'h6);
    wait_cnt(4);
    check("new_c4_out",  32'(phase_out),  32'h4);
    check("new_c4_rise", 32'(phase_rise), 32'h4);
    @(negedge clock);
    check("new_c5_out",  32'(phase_out),  32'h6);
    check("new_c5_rise", 32'(phase_rise), 32'h2);
    @(negedge clock);
    check("new_c6_out",  32'(phase_out),  32'hC);

    // Stop completes the period; re-enable while stopping leaves no gap.
    wait_cnt(2);
    enable = 1'b0;
    wait_cnt(7);
    check("stop_c7_run", 32'(running),   32'd1);
    check("stop_c7_out", 32'(phase_out), 32'hC);
    @(negedge clock);
    check("stopped_run", 32'(running),   32'd0);
    check("stopped_out", 32'(phase_out), 32'd0);
    repeat (2) @(negedge clock);
    enable = 1'b1;
    wait_cnt(2);
    enable = 1'b0;
    wait_cnt(5);
    enable = 1'b1;
    wait_cnt(7);
    @(negedge clock);
    check("reen_run", 32'(running),      32'd1);
    check("reen_ps",  32'(period_start), 32'd1);

    // Period validation against pending phases.
    write_ch(1, 2, 4);
    check("restore_err", 32'(cfg_err), 32'd0);
    write_period(4);
    check("p4_rej_err", 32'(cfg_err), 32'd1);
    @(negedge clock);
    check("err_pulse_end", 32'(cfg_err), 32'd0);
    write_ch(3, 1, 4);
    check("ch3_ok_err", 32'(cfg_err), 32'd0);
    write_period(4);
    check("p4_ok_err", 32'(cfg_err), 32'd0);
    write_ch(2, 4, 4);
    check("ph_eq_p_err", 32'(cfg_err), 32'd1);
    wait_cnt(0);
    wait_cnt(3);
    @(negedge clock);
    check("p4_wrap_cnt", 32'(cycle_cnt),    32'd0);
    check("p4_wrap_ps",  32'(period_start), 32'd1);
    check("p4_out",      32'(phase_out),    32'hF);

    // Width 0 never high; width beyond period stays high with one rise.
    write_ch(0, 0, 0);
    wait_cnt(0);
    for (int k = 0; k < 4; k++) begin
      check("w0_low", 32'(phase_out[0]), 32'd0);
      @(negedge clock);
    end
    write_ch(0, 0, 7);
    wait_cnt(0);
    check("w7_high", 32'(phase_out[0]),  32'd1);
    check("w7_rise", 32'(phase_rise[0]), 32'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      check("w7_hold", 32'(phase_out[0]),  32'd1);
      check("w7_norise", 32'(phase_rise[0]), 32'd0);
    end

    // Same-cycle period+phase writes: phase is judged against the resulting period.
    write_both(0, 3, 7, 2);
    check("both_ok_err", 32'(cfg_err), 32'd0);
    write_both(2, 0, 3, 4);
    check("both_rej_err", 32'(cfg_err), 32'd1);
    wait_cnt(0);
    wait_cnt(0);
    check("both_c0_out", 32'(phase_out), 32'h8);

    // Reset mid-period restores defaults.
    wait_cnt(5);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_out", 32'(phase_out), 32'd0);
    check("mid_rst_run", 32'(running),   32'd0);
    check("mid_rst_cnt", 32'(cycle_cnt), 32'd0);
    reset = 1'b0;
    check_default_pattern();

    // Period 1: counter pinned at 0, all channels constantly high.
    write_ch(1, 0, 4);
    write_ch(2, 0, 4);
    write_ch(3, 0, 4);
    write_period(1);
    check("p1_err", 32'(cfg_err), 32'd0);
    wait_cnt(0);
    for (int k = 0; k < 4; k++) begin
      check("p1_cnt", 32'(cycle_cnt),    32'd0);
      check("p1_ps",  32'(period_start), 32'd1);
      check("p1_out", 32'(phase_out),    32'hF);
      @(negedge clock);
    end
    enable = 1'b0;
    @(negedge clock);
    check("p1_stop_run", 32'(running),   32'd0);
    check("p1_stop_out", 32'(phase_out), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
